// File: rtl/dispatch_pkg.sv
// Shared constants, field positions and helpers for the dual-issue dispatch stage.
package dispatch_pkg;

  localparam logic [7:0] OP_LOAD  = 8'h01;
  localparam logic [7:0] OP_STORE = 8'h02;
  localparam logic [7:0] OP_ADD   = 8'h03;
  localparam logic [7:0] OP_MULTI = 8'h04;

  localparam logic [7:0] REG_FIRST = 8'h10;
  localparam logic [7:0] REG_LAST  = 8'h13;
  localparam int         NUM_REGS  = 4;

  localparam logic [7:0] TAG_A0  = 8'h20;
  localparam logic [7:0] TAG_M0  = 8'h30;
  localparam logic [7:0] TAG_LD0 = 8'h40;
  localparam logic [7:0] TAG_ST0 = 8'h50;

  localparam int NUM_ADD   = 3;
  localparam int NUM_MULT  = 2;
  localparam int NUM_LOAD  = 2;
  localparam int NUM_STORE = 2;

  localparam int BUS_TAG_HI = 39;
  localparam int BUS_TAG_LO = 32;
  localparam int OP_HI  = 31;
  localparam int OP_LO  = 24;
  localparam int DST_HI = 23;
  localparam int DST_LO = 16;
  localparam int S1_HI  = 15;
  localparam int S1_LO  = 8;
  localparam int S2_HI  = 7;
  localparam int S2_LO  = 0;

  typedef logic [39:0] tagbus_t;

  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_ADD,
    CLS_MULT,
    CLS_LOAD,
    CLS_STORE
  } rs_class_e;

  function automatic rs_class_e op_class(input logic [7:0] op);
    rs_class_e c;
    case (op)
      OP_ADD:   c = CLS_ADD;
      OP_MULTI: c = CLS_MULT;
      OP_LOAD:  c = CLS_LOAD;
      OP_STORE: c = CLS_STORE;
      default:  c = CLS_NONE;
    endcase
    return c;
  endfunction

  function automatic logic is_reg(input logic [7:0] id);
    return (id >= REG_FIRST) && (id <= REG_LAST);
  endfunction

  // Tag 0 on a broadcast means idle, so it never matches anything.
  function automatic logic tag_hit(input logic [7:0] t, input logic [3:0][7:0] bc);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bc[i] != 8'h00 && bc[i] == t) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic [7:0] rat_lookup(input logic [7:0] id, input logic [3:0][7:0] rat);
    logic [7:0] t;
    t = id;
    if (is_reg(id) && rat[id[1:0]] != 8'h00) t = rat[id[1:0]];
    return t;
  endfunction

endpackage

// File: rtl/dispatch_unit_rs_alloc.sv
// Priority free-slot finder: returns the lowest-numbered idle station of one class.
module rs_alloc
  import dispatch_pkg::*;
#(
  parameter int         N    = 2,
  parameter logic [7:0] BASE = 8'h20
) (
  input  logic [N-1:0] i_busy,
  output logic         o_found,
  output logic [7:0]   o_tag,
  output logic [N-1:0] o_grant
);

  always_comb begin
    o_found = 1'b0;
    o_tag   = 8'h00;
    o_grant = '0;
    // Scan downward so the lowest free index is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (!i_busy[i]) begin
        o_found    = 1'b1;
        o_tag      = BASE + 8'(i);
        o_grant    = '0;
        o_grant[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dispatch_unit.sv
// Dual-issue in-order dispatch: completion, RS allocation, RAT renaming, registered output buses.
module dispatch_unit
  import dispatch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst1,
  input  logic [31:0] inst2,
  input  logic [39:0] addbus,
  input  logic [39:0] multbus,
  input  logic [39:0] loadbus,
  input  logic [7:0]  storesig,
  output logic [39:0] instbus1,
  output logic [39:0] instbus2,
  output logic        stall1,
  output logic        stall2
);

  logic A0_flag, A1_flag, A2_flag;
  logic M0_flag, M1_flag;
  logic LD0_flag, LD1_flag;
  logic ST0_flag, ST1_flag;

  logic [3:0][7:0] r_rat;
  tagbus_t         r_bus1, r_bus2;

  logic [3:0][7:0] w_bc;
  logic            w_unused_data;
  logic [2:0]      w_add_pc, w_add_b2, w_add_nx;
  logic [1:0]      w_mult_pc, w_mult_b2, w_mult_nx;
  logic [1:0]      w_load_pc, w_load_b2, w_load_nx;
  logic [1:0]      w_store_pc, w_store_b2, w_store_nx;
  logic [3:0][7:0] w_rat_pc, w_rat_nx;

  assign w_bc = {storesig, loadbus[BUS_TAG_HI:BUS_TAG_LO],
                 multbus[BUS_TAG_HI:BUS_TAG_LO], addbus[BUS_TAG_HI:BUS_TAG_LO]};
  assign w_unused_data = ^{addbus[31:0], multbus[31:0], loadbus[31:0]};

  // Post-completion view: everything after this point sees freed stations and cleared RAT entries.
  always_comb begin
    for (int i = 0; i < NUM_ADD; i++)
      w_add_pc[i] = 1'b0;
    w_add_pc[0] = A0_flag & ~tag_hit(TAG_A0, w_bc);
    w_add_pc[1] = A1_flag & ~tag_hit(TAG_A0 + 8'd1, w_bc);
    w_add_pc[2] = A2_flag & ~tag_hit(TAG_A0 + 8'd2, w_bc);
    w_mult_pc[0]  = M0_flag  & ~tag_hit(TAG_M0, w_bc);
    w_mult_pc[1]  = M1_flag  & ~tag_hit(TAG_M0 + 8'd1, w_bc);
    w_load_pc[0]  = LD0_flag & ~tag_hit(TAG_LD0, w_bc);
    w_load_pc[1]  = LD1_flag & ~tag_hit(TAG_LD0 + 8'd1, w_bc);
    w_store_pc[0] = ST0_flag & ~tag_hit(TAG_ST0, w_bc);
    w_store_pc[1] = ST1_flag & ~tag_hit(TAG_ST0 + 8'd1, w_bc);
    for (int r = 0; r < NUM_REGS; r++)
      w_rat_pc[r] = tag_hit(r_rat[r], w_bc) ? 8'h00 : r_rat[r];
  end

  logic       w_a1_f, w_m1_f, w_l1_f, w_s1_f, w_a2_f, w_m2_f, w_l2_f, w_s2_f;
  logic [7:0] w_a1_t, w_m1_t, w_l1_t, w_s1_t, w_a2_t, w_m2_t, w_l2_t, w_s2_t;
  logic [2:0] w_a1_g, w_a2_g;
  logic [1:0] w_m1_g, w_l1_g, w_s1_g, w_m2_g, w_l2_g, w_s2_g;

  rs_alloc #(.N(NUM_ADD),   .BASE(TAG_A0))  u_add1   (.i_busy(w_add_pc),   .o_found(w_a1_f), .o_tag(w_a1_t), .o_grant(w_a1_g));
  rs_alloc #(.N(NUM_MULT),  .BASE(TAG_M0))  u_mult1  (.i_busy(w_mult_pc),  .o_found(w_m1_f), .o_tag(w_m1_t), .o_grant(w_m1_g));
  rs_alloc #(.N(NUM_LOAD),  .BASE(TAG_LD0)) u_load1  (.i_busy(w_load_pc),  .o_found(w_l1_f), .o_tag(w_l1_t), .o_grant(w_l1_g));
  rs_alloc #(.N(NUM_STORE), .BASE(TAG_ST0)) u_store1 (.i_busy(w_store_pc), .o_found(w_s1_f), .o_tag(w_s1_t), .o_grant(w_s1_g));
  rs_alloc #(.N(NUM_ADD),   .BASE(TAG_A0))  u_add2   (.i_busy(w_add_b2),   .o_found(w_a2_f), .o_tag(w_a2_t), .o_grant(w_a2_g));
  rs_alloc #(.N(NUM_MULT),  .BASE(TAG_M0))  u_mult2  (.i_busy(w_mult_b2),  .o_found(w_m2_f), .o_tag(w_m2_t), .o_grant(w_m2_g));
  rs_alloc #(.N(NUM_LOAD),  .BASE(TAG_LD0)) u_load2  (.i_busy(w_load_b2),  .o_found(w_l2_f), .o_tag(w_l2_t), .o_grant(w_l2_g));
  rs_alloc #(.N(NUM_STORE), .BASE(TAG_ST0)) u_store2 (.i_busy(w_store_b2), .o_found(w_s2_f), .o_tag(w_s2_t), .o_grant(w_s2_g));

  rs_class_e  w_cls1, w_cls2;
  logic       w_found1, w_found2, w_acc1, w_acc2, w_wr1, w_wr2;
  logic [7:0] w_tag1, w_tag2;
  logic [31:0] w_ren1, w_ren2;

  assign w_cls1 = op_class(inst1[OP_HI:OP_LO]);
  assign w_cls2 = op_class(inst2[OP_HI:OP_LO]);
  assign w_wr1  = (w_cls1 == CLS_ADD) || (w_cls1 == CLS_MULT) || (w_cls1 == CLS_LOAD);
  assign w_wr2  = (w_cls2 == CLS_ADD) || (w_cls2 == CLS_MULT) || (w_cls2 == CLS_LOAD);

  always_comb begin
    w_found1 = 1'b0;
    w_tag1   = 8'h00;
    case (w_cls1)
      CLS_ADD:   begin w_found1 = w_a1_f; w_tag1 = w_a1_t; end
      CLS_MULT:  begin w_found1 = w_m1_f; w_tag1 = w_m1_t; end
      CLS_LOAD:  begin w_found1 = w_l1_f; w_tag1 = w_l1_t; end
      CLS_STORE: begin w_found1 = w_s1_f; w_tag1 = w_s1_t; end
      default:   ;
    endcase
    w_found2 = 1'b0;
    w_tag2   = 8'h00;
    case (w_cls2)
      CLS_ADD:   begin w_found2 = w_a2_f; w_tag2 = w_a2_t; end
      CLS_MULT:  begin w_found2 = w_m2_f; w_tag2 = w_m2_t; end
      CLS_LOAD:  begin w_found2 = w_l2_f; w_tag2 = w_l2_t; end
      CLS_STORE: begin w_found2 = w_s2_f; w_tag2 = w_s2_t; end
      default:   ;
    endcase
  end

  assign stall1 = (w_cls1 != CLS_NONE) && !w_found1;
  assign w_acc1 = (w_cls1 != CLS_NONE) && w_found1;
  assign stall2 = stall1 || ((w_cls2 != CLS_NONE) && !w_found2);
  assign w_acc2 = (w_cls2 != CLS_NONE) && !stall2;

  // Slot 2 sees slot 1's grant as already taken.
  assign w_add_b2   = w_add_pc   | ((w_acc1 && w_cls1 == CLS_ADD)   ? w_a1_g : 3'b000);
  assign w_mult_b2  = w_mult_pc  | ((w_acc1 && w_cls1 == CLS_MULT)  ? w_m1_g : 2'b00);
  assign w_load_b2  = w_load_pc  | ((w_acc1 && w_cls1 == CLS_LOAD)  ? w_l1_g : 2'b00);
  assign w_store_b2 = w_store_pc | ((w_acc1 && w_cls1 == CLS_STORE) ? w_s1_g : 2'b00);

  assign w_add_nx   = w_add_b2   | ((w_acc2 && w_cls2 == CLS_ADD)   ? w_a2_g : 3'b000);
  assign w_mult_nx  = w_mult_b2  | ((w_acc2 && w_cls2 == CLS_MULT)  ? w_m2_g : 2'b00);
  assign w_load_nx  = w_load_b2  | ((w_acc2 && w_cls2 == CLS_LOAD)  ? w_l2_g : 2'b00);
  assign w_store_nx = w_store_b2 | ((w_acc2 && w_cls2 == CLS_STORE) ? w_s2_g : 2'b00);

  function automatic logic [7:0] src2_map(input logic [7:0] id);
    logic [7:0] t;
    if (w_acc1 && w_wr1 && id == inst1[DST_HI:DST_LO]) t = w_tag1;
    else                                               t = rat_lookup(id, w_rat_pc);
    return t;
  endfunction

  always_comb begin
    w_ren1 = inst1;
    case (w_cls1)
      CLS_ADD, CLS_MULT: begin
        w_ren1[S1_HI:S1_LO] = rat_lookup(inst1[S1_HI:S1_LO], w_rat_pc);
        w_ren1[S2_HI:S2_LO] = rat_lookup(inst1[S2_HI:S2_LO], w_rat_pc);
      end
      CLS_STORE: w_ren1[DST_HI:DST_LO] = rat_lookup(inst1[DST_HI:DST_LO], w_rat_pc);
      default:   ;
    endcase
    w_ren2 = inst2;
    case (w_cls2)
      CLS_ADD, CLS_MULT: begin
        w_ren2[S1_HI:S1_LO] = src2_map(inst2[S1_HI:S1_LO]);
        w_ren2[S2_HI:S2_LO] = src2_map(inst2[S2_HI:S2_LO]);
      end
      CLS_STORE: w_ren2[DST_HI:DST_LO] = src2_map(inst2[DST_HI:DST_LO]);
      default:   ;
    endcase
  end

  // Later writes win: inst2 over inst1, and any new dispatch over a same-cycle clear.
  always_comb begin
    w_rat_nx = w_rat_pc;
    if (w_acc1 && w_wr1 && is_reg(inst1[DST_HI:DST_LO]))
      w_rat_nx[inst1[DST_LO+1:DST_LO]] = w_tag1;
    if (w_acc2 && w_wr2 && is_reg(inst2[DST_HI:DST_LO]))
      w_rat_nx[inst2[DST_LO+1:DST_LO]] = w_tag2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      {A2_flag, A1_flag, A0_flag} <= 3'b000;
      {M1_flag, M0_flag}          <= 2'b00;
      {LD1_flag, LD0_flag}        <= 2'b00;
      {ST1_flag, ST0_flag}        <= 2'b00;
      r_rat  <= '0;
      r_bus1 <= '0;
      r_bus2 <= '0;
    end else begin
      {A2_flag, A1_flag, A0_flag} <= w_add_nx;
      {M1_flag, M0_flag}          <= w_mult_nx;
      {LD1_flag, LD0_flag}        <= w_load_nx;
      {ST1_flag, ST0_flag}        <= w_store_nx;
      r_rat  <= w_rat_nx;
      r_bus1 <= w_acc1 ? {w_tag1, w_ren1} : '0;
      r_bus2 <= w_acc2 ? {w_tag2, w_ren2} : '0;
    end
  end

  assign instbus1 = r_bus1;
  assign instbus2 = r_bus2;

endmodule

// File: tb/tb_dispatch_unit.sv
// Directed bench for dispatch_unit with hand-computed expected buses, stalls, flags and RAT.
module tb_dispatch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst1, inst2;
  logic [39:0] addbus, multbus, loadbus;
  logic [7:0]  storesig;
  logic [39:0] instbus1, instbus2;
  logic        stall1, stall2;

  int checks = 0;
  int errors = 0;

  dispatch_unit dut (
    .clk(clk), .rst(rst), .inst1(inst1), .inst2(inst2),
    .addbus(addbus), .multbus(multbus), .loadbus(loadbus), .storesig(storesig),
    .instbus1(instbus1), .instbus2(instbus2), .stall1(stall1), .stall2(stall2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inst1 = '0; inst2 = '0;
    addbus = '0; multbus = '0; loadbus = '0; storesig = '0;
  endtask

  function automatic logic [39:0] flags();
    return {31'd0, dut.A0_flag, dut.A1_flag, dut.A2_flag, dut.M0_flag, dut.M1_flag,
            dut.LD0_flag, dut.LD1_flag, dut.ST0_flag, dut.ST1_flag};
  endfunction

  initial begin
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    chk("reset_bus1", instbus1, 40'h0);
    chk("reset_bus2", instbus2, 40'h0);
    chk("reset_flags", flags(), 40'h0);
    chk("reset_rat", {8'h0, dut.r_rat}, 40'h0);
    chk("reset_stalls", {38'h0, stall1, stall2}, 40'h0);

    // Rename chain: LOAD R1 then MULTI reading R1
    inst1 = 32'h01110000; inst2 = 32'h04111112;
    #1;
    chk("chain_stalls", {38'h0, stall1, stall2}, 40'h0);
    tick(); idle();
    chk("chain_bus1", instbus1, 40'h4001110000);
    chk("chain_bus2", instbus2, 40'h3004114012);
    chk("chain_rat_r1", {32'h0, dut.r_rat[1]}, 40'h30);

    // Intra-bundle dependency
    inst1 = 32'h03131112; inst2 = 32'h03111113;
    #1;
    chk("dep_stalls", {38'h0, stall1, stall2}, 40'h0);
    tick(); idle();
    chk("dep_bus1", instbus1, 40'h2003133012);
    chk("dep_bus2", instbus2, 40'h2103113020);
    chk("dep_rat_r3", {32'h0, dut.r_rat[3]}, 40'h20);

    // Fill A2, then structural stall
    inst1 = 32'h03101010;
    tick(); idle();
    chk("fill_a2_bus1", instbus1, 40'h2203101010);
    inst1 = 32'h03121010;
    #1;
    chk("struct_stalls", {38'h0, stall1, stall2}, 40'h3);
    tick();
    chk("struct_bus1", instbus1, 40'h0);
    chk("struct_bus2", instbus2, 40'h0);
    addbus = 40'h2023451234;
    #1;
    chk("free_same_cycle_stall1", {39'h0, stall1}, 40'h0);
    tick(); idle();
    chk("free_same_cycle_bus1", instbus1, 40'h2003122222);
    chk("free_rat_r3_cleared", {32'h0, dut.r_rat[3]}, 40'h0);
    chk("free_rat_r2", {32'h0, dut.r_rat[2]}, 40'h20);

    // Completion clears RAT
    loadbus = 40'h40DEADBEEF; addbus = 40'h2100000007;
    tick(); idle();
    chk("cmpl_rat_r1", {32'h0, dut.r_rat[1]}, 40'h0);
    chk("cmpl_flags", flags(), 40'b1_0_1_1_0_0_0_0_0);
    inst1 = 32'h01110004;
    tick(); idle();
    chk("load_bus1", instbus1, 40'h4001110004);
    loadbus = 40'h4000000055;
    tick(); idle();
    inst1 = 32'h03111111;
    tick(); idle();
    chk("add_after_load_bus1", instbus1, 40'h2103111111);

    // Store and NOP
    inst1 = 32'h02110000;
    tick(); idle();
    chk("store_bus1", instbus1, 40'h5002210000);
    storesig = 8'h50;
    tick(); idle();
    chk("store_freed_flag", {39'h0, dut.ST0_flag}, 40'h0);
    inst1 = 32'h02120000;
    tick(); idle();
    chk("store_reuse_bus1", instbus1, 40'h5002200000);
    inst1 = 32'h00000000; inst2 = 32'hFF121314;
    #1;
    chk("nop_stalls", {38'h0, stall1, stall2}, 40'h0);
    tick(); idle();
    chk("nop_bus1", instbus1, 40'h0);
    chk("nop_bus2", instbus2, 40'h0);

    // Only slot 2 runs out of multiplier stations
    inst1 = 32'h04101010; inst2 = 32'h04121212;
    #1;
    chk("stall2_only", {38'h0, stall1, stall2}, 40'h1);
    tick(); idle();
    chk("stall2_only_bus1", instbus1, 40'h3104102222);
    chk("stall2_only_bus2", instbus2, 40'h0);

    // Reset mid-operation, with a valid ADD presented on the reset edge
    rst = 1'b1; inst1 = 32'h03101112;
    tick();
    rst = 1'b0; idle();
    chk("rst_mid_bus1", instbus1, 40'h0);
    chk("rst_mid_bus2", instbus2, 40'h0);
    chk("rst_mid_flags", flags(), 40'h0);
    chk("rst_mid_rat", {8'h0, dut.r_rat}, 40'h0);
    inst1 = 32'h03101112;
    tick(); idle();
    chk("post_rst_add_bus1", instbus1, 40'h2003101112);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
